thumb_dp_issue: RTL and testbench

THUMB_DP_ISSUE -- requirements
Module: thumb_dp_issue

---
 rtl/thumb_dp_pkg.sv | 67 ++++++
 rtl/thumb_dp_dec.sv | 77 +++++++
 rtl/thumb_dp_issue.sv | 168 ++++++++++++++++
 tb/tb_thumb_dp_issue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/thumb_dp_pkg.sv
// Shared types and constants for the Thumb data-processing issue slice:
// ALU opcode encoding, FSM states, instruction prefixes and the decode record.
package thumb_dp_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_ADC  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_RSB  = 4'h3,
    ALU_SBC  = 4'h4,
    ALU_AND  = 4'h5,
    ALU_ORR  = 4'h6,
    ALU_EOR  = 4'h7,
    ALU_MOV  = 4'h8,
    ALU_RSV9 = 4'h9,
    ALU_RSVA = 4'hA,
    ALU_RSVB = 4'hB,
    ALU_MVN  = 4'hC
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // instr[15:9] prefixes of the three-operand add/sub group
  localparam logic [6:0] PFX_ADDS_REG  = 7'b0001100;
  localparam logic [6:0] PFX_SUBS_REG  = 7'b0001101;
  localparam logic [6:0] PFX_ADDS_IMM3 = 7'b0001110;
  localparam logic [6:0] PFX_SUBS_IMM3 = 7'b0001111;

  // instr[15:11] prefixes of the imm8 group
  localparam logic [4:0] PFX_MOVS_IMM8 = 5'b00100;
  localparam logic [4:0] PFX_CMP_IMM8  = 5'b00101;
  localparam logic [4:0] PFX_ADDS_IMM8 = 5'b00110;
  localparam logic [4:0] PFX_SUBS_IMM8 = 5'b00111;

  // instr[15:10] prefix of the register data-processing group, op in [9:6]
  localparam logic [5:0] PFX_DP = 6'b010000;
  localparam logic [3:0] DP_AND = 4'h0;
  localparam logic [3:0] DP_EOR = 4'h1;
  localparam logic [3:0] DP_ADC = 4'h5;
  localparam logic [3:0] DP_SBC = 4'h6;
  localparam logic [3:0] DP_TST = 4'h8;
  localparam logic [3:0] DP_RSB = 4'h9;
  localparam logic [3:0] DP_CMP = 4'hA;
  localparam logic [3:0] DP_CMN = 4'hB;
  localparam logic [3:0] DP_ORR = 4'hC;
  localparam logic [3:0] DP_MVN = 4'hF;

  // Decoded instruction: op1 = imm when op1_imm else R[ra];
  // op2 = R[rb] when op2_reg else imm.
  typedef struct packed {
    alu_op_e     opcode;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        op1_imm;
    logic        op2_reg;
    logic [31:0] imm;
    logic        we;
    logic        undef;
  } dec_t;

endpackage

// File: rtl/thumb_dp_dec.sv
// Combinational Thumb data-processing decoder. Anything outside the supported
// subset comes out as an all-zero record with undef set.
module thumb_dp_dec
  import thumb_dp_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  alu_op_e dp_op;
  logic    dp_ok;
  logic    dp_we;
  logic    dp_unary;

  // classify the register data-processing op field
  always_comb begin
    dp_op    = ALU_ADD;
    dp_ok    = 1'b1;
    dp_we    = 1'b1;
    dp_unary = 1'b0;
    case (instr[9:6])
      DP_AND: dp_op = ALU_AND;
      DP_EOR: dp_op = ALU_EOR;
      DP_ADC: dp_op = ALU_ADC;
      DP_SBC: dp_op = ALU_SBC;
      DP_TST: begin dp_op = ALU_AND; dp_we = 1'b0; end
      DP_RSB: begin dp_op = ALU_RSB; dp_unary = 1'b1; end
      DP_CMP: begin dp_op = ALU_SUB; dp_we = 1'b0; end
      DP_CMN: begin dp_op = ALU_ADD; dp_we = 1'b0; end
      DP_ORR: dp_op = ALU_ORR;
      DP_MVN: begin dp_op = ALU_MVN; dp_unary = 1'b1; end
      default: dp_ok = 1'b0;
    endcase
  end

  // build the decode record for the whole instruction
  always_comb begin
    dec       = '0;
    dec.undef = 1'b1;
    if (instr[15:9] == PFX_ADDS_REG || instr[15:9] == PFX_SUBS_REG ||
        instr[15:9] == PFX_ADDS_IMM3 || instr[15:9] == PFX_SUBS_IMM3) begin
      dec.undef   = 1'b0;
      dec.we      = 1'b1;
      dec.opcode  = instr[9] ? ALU_SUB : ALU_ADD;
      dec.rd      = instr[2:0];
      dec.ra      = instr[5:3];
      dec.rb      = instr[8:6];
      dec.op2_reg = ~instr[10];
      dec.imm     = {29'd0, instr[8:6]};
    end else if (instr[15:11] == PFX_MOVS_IMM8 || instr[15:11] == PFX_CMP_IMM8 ||
                 instr[15:11] == PFX_ADDS_IMM8 || instr[15:11] == PFX_SUBS_IMM8) begin
      dec.undef = 1'b0;
      dec.we    = (instr[15:11] != PFX_CMP_IMM8);
      dec.rd    = instr[10:8];
      dec.ra    = instr[10:8];
      dec.imm   = {24'd0, instr[7:0]};
      if (instr[15:11] == PFX_MOVS_IMM8) begin
        dec.opcode  = ALU_MOV;
        dec.op1_imm = 1'b1;
      end else if (instr[15:11] == PFX_ADDS_IMM8) begin
        dec.opcode = ALU_ADD;
      end else begin
        dec.opcode = ALU_SUB;
      end
    end else if (instr[15:10] == PFX_DP && dp_ok) begin
      // RSBS/MVNS take their single source from the Rm field; op2 is zero
      dec.undef   = 1'b0;
      dec.we      = dp_we;
      dec.opcode  = dp_op;
      dec.rd      = instr[2:0];
      dec.ra      = dp_unary ? instr[5:3] : instr[2:0];
      dec.rb      = instr[5:3];
      dec.op2_reg = ~dp_unary;
    end
  end

endmodule

// File: rtl/thumb_dp_issue.sv
// Thumb data-processing issue stage: accepts one 16-bit instruction, decodes
// it, drives an external combinational ALU, commits Rd/APSR and presents the
// completion on a valid/ready port.
// Optional macro THUMB_DP_ALU_OUT_REG_EN registers the ALU response and adds
// an EXEC2 state before commit (one extra cycle of latency).
module thumb_dp_issue
  import thumb_dp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_flag,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flag_q,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [2:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        undef,
  output logic [3:0]  apsr_nzcv
);

  state_e      state_reg;
  logic [15:0] instr_reg;
  logic        loaded_reg;   // EXEC has registered the decode and operands
  logic [2:0]  rd_reg;
  logic        we_reg;
  logic        undef_reg;
  logic [31:0] regs_reg [8];
  logic [3:0]  apsr_reg;

  dec_t        dec;
  logic [31:0] op1_next;
  logic [31:0] op2_next;
  logic        commit;
  logic        commit_wr;
  logic [31:0] commit_data;
  logic [3:0]  commit_flags;

  thumb_dp_dec u_dec (
    .instr (instr_reg),
    .dec   (dec)
  );

  assign instr_ready = (state_reg == ST_IDLE);
  assign apsr_nzcv   = apsr_reg;

`ifdef THUMB_DP_ALU_OUT_REG_EN
  logic [31:0] res_reg;
  logic [3:0]  flag_q_reg;
  assign commit       = (state_reg == ST_EXEC2);
  assign commit_data  = res_reg;
  assign commit_flags = flag_q_reg;
`else
  assign commit       = (state_reg == ST_EXEC) && loaded_reg;
  assign commit_data  = alu_result;
  assign commit_flags = alu_flag_q;
`endif

  assign commit_wr = commit && we_reg && !undef_reg;

  // operand selection from the register file and the immediate
  always_comb begin
    op1_next = dec.op1_imm ? dec.imm : regs_reg[dec.ra];
    op2_next = dec.op2_reg ? regs_reg[dec.rb] : dec.imm;
  end

  // control FSM with registered ALU request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      instr_reg  <= '0;
      loaded_reg <= 1'b0;
      rd_reg     <= '0;
      we_reg     <= 1'b0;
      undef_reg  <= 1'b0;
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_flag   <= '0;
`ifdef THUMB_DP_ALU_OUT_REG_EN
      res_reg    <= '0;
      flag_q_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_reg  <= instr;
            loaded_reg <= 1'b0;
            state_reg  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!loaded_reg) begin
            loaded_reg <= 1'b1;
            rd_reg     <= dec.rd;
            we_reg     <= dec.we;
            undef_reg  <= dec.undef;
            // undefined encodings leave the ALU request at zero
            if (!dec.undef) begin
              alu_opcode <= dec.opcode;
              alu_op1    <= op1_next;
              alu_op2    <= op2_next;
              alu_flag   <= apsr_reg;
            end
          end else begin
`ifdef THUMB_DP_ALU_OUT_REG_EN
            res_reg    <= alu_result;
            flag_q_reg <= alu_flag_q;
            state_reg  <= ST_EXEC2;
`else
            state_reg  <= ST_RESP;
`endif
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_flag   <= '0;
          end
        end
`ifdef THUMB_DP_ALU_OUT_REG_EN
        ST_EXEC2: state_reg <= ST_RESP;
`endif
        ST_RESP: begin
          if (wb_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // completion outputs and flag register, updated on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_we    <= 1'b0;
      undef    <= 1'b0;
      apsr_reg <= '0;
    end else if (commit) begin
      wb_valid <= 1'b1;
      wb_rd    <= undef_reg ? 3'd0 : rd_reg;
      wb_data  <= undef_reg ? 32'd0 : commit_data;
      wb_we    <= we_reg && !undef_reg;
      undef    <= undef_reg;
      if (!undef_reg) apsr_reg <= commit_flags;
    end else if (state_reg == ST_RESP && wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  // low register file R0-R7
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_reg[i] <= '0;
    end else if (commit_wr) begin
      regs_reg[rd_reg] <= commit_data;
    end
  end

endmodule

// File: tb/tb_thumb_dp_issue.sv
// Directed bench for thumb_dp_issue with a behavioural ALU model.
module tb_thumb_dp_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0000;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_flag;
  logic [31:0] alu_result;
  logic [3:0]  alu_flag_q;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        undef;
  logic [3:0]  apsr_nzcv;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef THUMB_DP_ALU_OUT_REG_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  typedef struct {
    logic [15:0] instr;
    logic [31:0] data;
    logic [2:0]  rd;
    logic        we;
    logic        undef;
    logic [3:0]  nzcv;
    int          stall;
  } vec_t;

  vec_t vq[$];

  thumb_dp_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_flag    (alu_flag),
    .alu_result  (alu_result),
    .alu_flag_q  (alu_flag_q),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_we       (wb_we),
    .undef       (undef),
    .apsr_nzcv   (apsr_nzcv)
  );

  always #5 clk = ~clk;

  // behavioural ALU: arithmetic sets NZCV, logical/move keep C and V
  logic [31:0] m_a, m_b;
  logic        m_cin, m_arith;
  logic [32:0] m_sum;
  always_comb begin
    m_a = '0; m_b = '0; m_cin = 1'b0; m_arith = 1'b0; m_sum = '0;
    alu_result = '0;
    alu_flag_q = alu_flag;
    case (alu_opcode)
      4'h0: begin m_a = alu_op1; m_b = alu_op2;  m_cin = 1'b0;        m_arith = 1'b1; end
      4'h1: begin m_a = alu_op1; m_b = alu_op2;  m_cin = alu_flag[1]; m_arith = 1'b1; end
      4'h2: begin m_a = alu_op1; m_b = ~alu_op2; m_cin = 1'b1;        m_arith = 1'b1; end
      4'h3: begin m_a = alu_op2; m_b = ~alu_op1; m_cin = 1'b1;        m_arith = 1'b1; end
      4'h4: begin m_a = alu_op1; m_b = ~alu_op2; m_cin = alu_flag[1]; m_arith = 1'b1; end
      4'h5: alu_result = alu_op1 & alu_op2;
      4'h6: alu_result = alu_op1 | alu_op2;
      4'h7: alu_result = alu_op1 ^ alu_op2;
      4'h8: alu_result = alu_op2;
      4'hC: alu_result = ~alu_op1;
      default: alu_result = '0;
    endcase
    if (m_arith) begin
      m_sum = {1'b0, m_a} + {1'b0, m_b} + {32'd0, m_cin};
      alu_result = m_sum[31:0];
      alu_flag_q[1] = m_sum[32];
      alu_flag_q[0] = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
    end
    alu_flag_q[3] = alu_result[31];
    alu_flag_q[2] = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_resp(input vec_t v);
    chk("wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("wb_data", wb_data, v.data);
    chk("wb_rd", {29'd0, wb_rd}, {29'd0, v.rd});
    chk("wb_we", {31'd0, wb_we}, {31'd0, v.we});
    chk("undef", {31'd0, undef}, {31'd0, v.undef});
    chk("nzcv", {28'd0, apsr_nzcv}, {28'd0, v.nzcv});
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    chk("instr_ready_idle", {31'd0, instr_ready}, 32'd1);
    instr = v.instr;
    instr_valid = 1'b1;
    wb_ready = (v.stall == 0);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'h0000;
    cyc = 0;
    while (!wb_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, EXP_LAT);
    check_resp(v);
    $display("txn instr=%h wb_data=%h rd=%0d we=%b undef=%b nzcv=%b lat=%0d",
             v.instr, wb_data, wb_rd, wb_we, undef, apsr_nzcv, cyc);
    for (int s = 0; s < v.stall; s++) begin
      if (s == 0) begin
        instr = 16'h27FF;
        instr_valid = 1'b1;
      end
      @(negedge clk);
      chk("stall_instr_ready", {31'd0, instr_ready}, 32'd0);
      check_resp(v);
    end
    instr_valid = 1'b0;
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("wb_valid_after_hs", {31'd0, wb_valid}, 32'd0);
    chk("instr_ready_after_hs", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wb_we"}, {31'd0, wb_we}, 32'd0);
    chk({tag, "_undef"}, {31'd0, undef}, 32'd0);
    chk({tag, "_wb_rd"}, {29'd0, wb_rd}, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_alu_opcode"}, {28'd0, alu_opcode}, 32'd0);
    chk({tag, "_alu_op1"}, alu_op1, 32'd0);
    chk({tag, "_alu_op2"}, alu_op2, 32'd0);
    chk({tag, "_alu_flag"}, {28'd0, alu_flag}, 32'd0);
    chk({tag, "_apsr"}, {28'd0, apsr_nzcv}, 32'd0);
    chk({tag, "_instr_ready"}, {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    //           instr     data          rd    we    undef nzcv     stall
    vq.push_back('{16'h2100, 32'h00000000, 3'd1, 1'b1, 1'b0, 4'b0100, 0}); // MOVS R1,#0
    vq.push_back('{16'h43C8, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0, 4'b1000, 0}); // MVNS R0,R1
    vq.push_back('{16'h1C40, 32'h00000000, 3'd0, 1'b1, 1'b0, 4'b0110, 0}); // ADDS R0,R0,#1
    vq.push_back('{16'h2205, 32'h00000005, 3'd2, 1'b1, 1'b0, 4'b0010, 0}); // MOVS R2,#5
    vq.push_back('{16'h2305, 32'h00000005, 3'd3, 1'b1, 1'b0, 4'b0010, 0}); // MOVS R3,#5
    vq.push_back('{16'h429A, 32'h00000000, 3'd2, 1'b0, 1'b0, 4'b0110, 5}); // CMP R2,R3 (stalled)
    vq.push_back('{16'h2080, 32'h00000080, 3'd0, 1'b1, 1'b0, 4'b0010, 0}); // MOVS R0,#0x80
    vq.push_back('{16'h4088, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'b0010, 0}); // LSLS: undef
    vq.push_back('{16'h1C00, 32'h00000080, 3'd0, 1'b1, 1'b0, 4'b0000, 0}); // ADDS R0,R0,#0
    vq.push_back('{16'h18D4, 32'h0000000A, 3'd4, 1'b1, 1'b0, 4'b0000, 0}); // ADDS R4,R2,R3
    vq.push_back('{16'h3801, 32'h0000007F, 3'd0, 1'b1, 1'b0, 4'b0010, 0}); // SUBS R0,#1
    vq.push_back('{16'h4040, 32'h00000000, 3'd0, 1'b1, 1'b0, 4'b0110, 0}); // EORS R0,R0
    vq.push_back('{16'h42E4, 32'h00000014, 3'd4, 1'b0, 1'b0, 4'b0000, 0}); // CMN R4,R4
    vq.push_back('{16'h4224, 32'h0000000A, 3'd4, 1'b0, 1'b0, 4'b0000, 0}); // TST R4,R4
    vq.push_back('{16'h4265, 32'hFFFFFFF6, 3'd5, 1'b1, 1'b0, 4'b1000, 0}); // RSBS R5,R4,#0
    vq.push_back('{16'h431D, 32'hFFFFFFF7, 3'd5, 1'b1, 1'b0, 4'b1000, 0}); // ORRS R5,R3
    vq.push_back('{16'h4348, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'b1000, 0}); // MULS: undef
    vq.push_back('{16'h1AE6, 32'h00000005, 3'd6, 1'b1, 1'b0, 4'b0010, 0}); // SUBS R6,R4,R3
    vq.push_back('{16'h4176, 32'h0000000B, 3'd6, 1'b1, 1'b0, 4'b0000, 0}); // ADCS R6,R6
    vq.push_back('{16'h419E, 32'h00000005, 3'd6, 1'b1, 1'b0, 4'b0010, 0}); // SBCS R6,R3
    vq.push_back('{16'h3607, 32'h0000000C, 3'd6, 1'b1, 1'b0, 4'b0000, 0}); // ADDS R6,#7
    vq.push_back('{16'h1E77, 32'h0000000B, 3'd7, 1'b1, 1'b0, 4'b0010, 0}); // SUBS R7,R6,#1
    vq.push_back('{16'h4388, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'b0010, 0}); // BICS: undef

    // power-on reset
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) run_vec(vq[i]);

    // reset while ADDS R0,R0,#1 sits in EXEC
    @(negedge clk);
    instr = 16'h1C40;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    chk("exec_alu_op1", alu_op1, 32'd0);
    chk("exec_alu_op2", alu_op2, 32'd1);
    chk("exec_alu_flag", {28'd0, alu_flag}, 32'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    run_vec('{16'h1C00, 32'h00000000, 3'd0, 1'b1, 1'b0, 4'b0100, 0}); // R0 cleared
    run_vec('{16'h18D4, 32'h00000000, 3'd4, 1'b1, 1'b0, 4'b0100, 0}); // R2,R3 cleared

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
